sd_card_cmd_responder: RTL and testbench
========================================

Name: sd_card_cmd_responder

Overview:
- Synthesizable card-side model of the SD command line, sitting directly upstream of the controller's sd_cmd_dat_i input.
- Deserializes 48-bit host commands, checks framing and CRC7, then serializes the matching R1/R2/R3 response back to the host after a fixed NCR gap.
- Used in the sdc_controller bench in place of random sd_cmd_dat_i toggling, so command/response paths see protocol-correct traffic.

Parameters:
- NCR, 2, idle cycles between sampling the command end bit and driving the response start bit; legal range 2..64.
- R2_IDX_MASK, 64'h0000_0000_0000_0604, bit n set means command index n gets an R2 (136-bit) response; default covers CMD2, CMD9, CMD10.

Ports:
- wb_clk_i  in  1  clock; one SD bit per cycle.
- wb_rst_i  in  1  synchronous, active-high reset.
- cmd_i  in  1  host command line value (controller sd_cmd_out_o).
- cmd_oe_i  in  1  host drives the command line.
- cmd_o  out  1  card-driven line value (to controller sd_cmd_dat_i when cmd_oe_o=1, else pulled high).
- cmd_oe_o  out  1  card drives the line.
- status_i  in  32  card status returned in R1; sampled at TX entry.
- ocr_i  in  32  OCR returned in R3 (CMD41); sampled at TX entry.
- cid_csd_i  in  120  R2 payload bits [127:8]; sampled at TX entry.
- cmd_valid_o  out  1  one-cycle pulse: a good command was received.
- cmd_idx_o  out  6  index of the last good command.
- cmd_arg_o  out  32  argument of the last good command.
- crc_err_o  out  1  one-cycle pulse: bad CRC7, bad transmission bit or bad end bit.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset: cmd_o=1, cmd_oe_o=0, cmd_valid_o=0, crc_err_o=0, cmd_idx_o=0, cmd_arg_o=0, busy_o=0, state IDLE.
- Frame format, MSB first: start 0, transmission bit, index[5:0], arg/payload, crc7[6:0], end 1.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over every bit preceding the CRC field.
- IDLE: a cycle with cmd_oe_i=1 and cmd_i=0 is the start bit → RX with bit count 1.
- RX: shift cmd_i while cmd_oe_i=1. If cmd_oe_i drops before 48 bits → IDLE, no pulse. After bit 48 → CHECK.
- CHECK (1 cycle):
  - Transmission bit=1, CRC matches and end bit=1 → latch idx/arg, pulse cmd_valid_o.
  - Otherwise → pulse crc_err_o, go to IDLE, send no response.
- Response selection after a good command:
  - Index 0 → no response, IDLE.
  - Index 41 → R3: index field 6'h3F, payload ocr_i, CRC field 7'h7F.
  - Index bit set in R2_IDX_MASK → R2: 136 bits = 0, 0, 6'h3F, cid_csd_i, CRC7 over cid_csd_i, 1.
  - Any other index → R1: 0, 0, idx, status_i, CRC7, 1.
- WAIT: the end bit is sampled in cycle T. cmd_oe_o rises with the start bit on cmd_o at cycle T+NCR; the CHECK cycle counts inside NCR.
- TX: one bit per cycle, cmd_oe_o=1 throughout. After the end bit: cmd_oe_o=0, cmd_o=1, IDLE.
- Collision: cmd_oe_i=1 during WAIT or TX → release the line on the next cycle, go to IDLE, drop the remaining response, no pulse.
- Back-to-back: a new start bit is accepted in the first IDLE cycle after TX or after an error.
- Reset asserted mid-RX or mid-TX → all reset values on the next cycle.

Test Plan:
- CMD0: host sends 0x40_00000000_95 → cmd_valid_o pulse, cmd_idx_o=0, cmd_oe_o stays 0.
- CMD55 with status_i=32'h00000120: host sends 0x77_00000000_65 → response 0x37_00000120_83 serialized; start bit exactly NCR=2 cycles after the end bit.
- CMD8 with arg 0x1AA: host sends 0x48_000001AA_87 → cmd_arg_o=32'h1AA, R1 echoes idx 8. Repeat with CRC byte 0x86 → crc_err_o pulse, no response.
- CMD41 with ocr_i=32'h80FF8000 → 48-bit R3 = 0x3F_80FF8000_FF.
- CMD2 with cid_csd_i set to a known value → 136-bit R2 with 6'h3F header and CRC7 matching the golden model.
- Host asserts cmd_oe_i at the 10th response bit, and separately cmd_oe_i drops at RX bit 20 → line released, IDLE, no pulses. Reset pulsed mid-TX → cmd_oe_o=0 on the next cycle.

Source files
------------

// File: rtl/sd_card_cmd_responder_if.sv
// rtl/sd_card_cmd_responder_if.sv - SD command-line signals between host and card-side responder
interface sd_card_cmd_responder_if;
    logic         cmd_i;
    logic         cmd_oe_i;
    logic         cmd_o;
    logic         cmd_oe_o;
    logic [31:0]  status_i;
    logic [31:0]  ocr_i;
    logic [119:0] cid_csd_i;
    logic         cmd_valid_o;
    logic [5:0]   cmd_idx_o;
    logic [31:0]  cmd_arg_o;
    logic         crc_err_o;
    logic         busy_o;

    modport slave (
        input  cmd_i, cmd_oe_i, status_i, ocr_i, cid_csd_i,
        output cmd_o, cmd_oe_o, cmd_valid_o, cmd_idx_o, cmd_arg_o, crc_err_o, busy_o
    );

    modport master (
        output cmd_i, cmd_oe_i, status_i, ocr_i, cid_csd_i,
        input  cmd_o, cmd_oe_o, cmd_valid_o, cmd_idx_o, cmd_arg_o, crc_err_o, busy_o
    );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// rtl/sd_card_cmd_responder.sv - card-side SD command deserializer, checker and R1/R2/R3 responder
module sd_card_cmd_responder #(
    parameter int          NCR         = 2,
    parameter logic [63:0] R2_IDX_MASK = 64'h0000_0000_0000_0604
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    sd_card_cmd_responder_if.slave   bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_RX, ST_CHECK, ST_WAIT, ST_TX} state_t;
    typedef enum logic [1:0] {RSP_R1, RSP_R2, RSP_R3} rsp_t;

    // The CHECK cycle is already one cycle of the NCR gap.
    localparam logic [5:0] WAIT_INIT = 6'(NCR - 2);

    state_t        state;
    rsp_t          rsp;
    logic [47:0]   rx_sr;
    logic [5:0]    rx_cnt;
    logic [5:0]    wait_cnt;
    logic [135:0]  tx_sr;
    logic [7:0]    bits_left;

    // Zero-initialised CRC7: leading zeros leave the register at zero, so short
    // messages are right-aligned into the 120-bit input.
    function automatic logic [6:0] crc7(input logic [119:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 119; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    logic         rx_good;
    logic [5:0]   rx_idx;
    logic [39:0]  r1_head;
    logic [135:0] tx_frame;
    logic [7:0]   tx_len;

    assign rx_idx  = rx_sr[45:40];
    assign rx_good = rx_sr[46] & rx_sr[0] & (crc7({80'b0, rx_sr[47:8]}) == rx_sr[7:1]);
    assign r1_head = {2'b00, bus.cmd_idx_o, bus.status_i};
    assign bus.busy_o = (state != ST_IDLE);

    // Frames are left-aligned so TX always shifts from bit 135.
    always_comb begin
        tx_frame = '0;
        tx_len   = 8'd48;
        case (rsp)
            RSP_R3: tx_frame = {2'b00, 6'h3F, bus.ocr_i, 7'h7F, 1'b1, 88'b0};
            RSP_R2: begin
                tx_frame = {2'b00, 6'h3F, bus.cid_csd_i, crc7(bus.cid_csd_i), 1'b1};
                tx_len   = 8'd136;
            end
            default: tx_frame = {r1_head, crc7({80'b0, r1_head}), 1'b1, 88'b0};
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state           <= ST_IDLE;
            rsp             <= RSP_R1;
            rx_sr           <= '0;
            rx_cnt          <= '0;
            wait_cnt        <= '0;
            tx_sr           <= '0;
            bits_left       <= '0;
            bus.cmd_o       <= 1'b1;
            bus.cmd_oe_o    <= 1'b0;
            bus.cmd_valid_o <= 1'b0;
            bus.crc_err_o   <= 1'b0;
            bus.cmd_idx_o   <= '0;
            bus.cmd_arg_o   <= '0;
        end else begin
            bus.cmd_valid_o <= 1'b0;
            bus.crc_err_o   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_oe_i && !bus.cmd_i) begin
                        rx_sr  <= '0;
                        rx_cnt <= 6'd1;
                        state  <= ST_RX;
                    end
                end
                ST_RX: begin
                    if (!bus.cmd_oe_i) begin
                        state <= ST_IDLE;
                    end else begin
                        rx_sr  <= {rx_sr[46:0], bus.cmd_i};
                        rx_cnt <= rx_cnt + 6'd1;
                        if (rx_cnt == 6'd47) state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!rx_good) begin
                        bus.crc_err_o <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        bus.cmd_valid_o <= 1'b1;
                        bus.cmd_idx_o   <= rx_idx;
                        bus.cmd_arg_o   <= rx_sr[39:8];
                        wait_cnt        <= WAIT_INIT;
                        if (rx_idx == 6'd0)           state <= ST_IDLE;
                        else                          state <= ST_WAIT;
                        if (rx_idx == 6'd41)          rsp <= RSP_R3;
                        else if (R2_IDX_MASK[rx_idx]) rsp <= RSP_R2;
                        else                          rsp <= RSP_R1;
                    end
                end
                ST_WAIT: begin
                    if (bus.cmd_oe_i) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == 6'd0) begin
                        bus.cmd_oe_o <= 1'b1;
                        bus.cmd_o    <= tx_frame[135];
                        tx_sr        <= {tx_frame[134:0], 1'b0};
                        bits_left    <= tx_len - 8'd1;
                        state        <= ST_TX;
                    end else begin
                        wait_cnt <= wait_cnt - 6'd1;
                    end
                end
                ST_TX: begin
                    if (bus.cmd_oe_i || bits_left == 8'd0) begin
                        bus.cmd_oe_o <= 1'b0;
                        bus.cmd_o    <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        bus.cmd_o <= tx_sr[135];
                        tx_sr     <= {tx_sr[134:0], 1'b0};
                        bits_left <= bits_left - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// tb/tb_sd_card_cmd_responder.sv - self-checking bench for sd_card_cmd_responder
module tb_sd_card_cmd_responder;
    localparam int          NCR    = 2;
    localparam logic [63:0] MASK   = 64'h0000_0000_0000_0604;
    localparam int          SETTLE = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sd_card_cmd_responder_if bus();

    sd_card_cmd_responder #(.NCR(NCR), .R2_IDX_MASK(MASK)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    typedef struct {
        string         name;
        logic [47:0]   frame;
        logic [31:0]   status;
        logic [31:0]   ocr;
        logic [119:0]  cid;
        int            exp_valid;
        int            exp_err;
        logic [5:0]    exp_idx;
        logic [31:0]   exp_arg;
        int            exp_len;
        logic [135:0]  exp_rsp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int end_cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    bit rsp_q[$];
    int rise_q[$];
    bit prev_oe = 1'b0;
    logic [5:0]  model_idx = '0;
    logic [31:0] model_arg = '0;
    vec_t vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: pulse counts, every bit driven by the card, cycle of each drive start.
    always @(negedge clk) begin
        if (bus.cmd_valid_o) valid_cnt++;
        if (bus.crc_err_o) err_cnt++;
        if (bus.cmd_oe_o) begin
            if (!prev_oe) rise_q.push_back(cyc);
            rsp_q.push_back(bus.cmd_o);
        end
        prev_oe = bus.cmd_oe_o;
    end

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of polynomial long division by x^7+x^3+1.
    function automatic logic [6:0] ref_crc7(input logic [119:0] d, input int n);
        bit r[127];
        bit [7:0] poly;
        logic [6:0] res;
        poly = 8'b1000_1001;
        for (int i = 0; i < 127; i++) r[i] = 1'b0;
        for (int i = 0; i < n; i++) r[i] = d[n-1-i];
        for (int i = 0; i < n; i++)
            if (r[i]) for (int k = 0; k < 8; k++) r[i+k] ^= poly[7-k];
        for (int i = 0; i < 7; i++) res[6-i] = r[n+i];
        return res;
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, ref_crc7({80'b0, h}, 40), 1'b1};
    endfunction

    task automatic model(input logic [47:0] f, input logic [31:0] st, input logic [31:0] oc,
                         input logic [119:0] cid, output vec_t v);
        logic [5:0] idx;
        v.name = "rand"; v.frame = f; v.status = st; v.ocr = oc; v.cid = cid;
        v.exp_len = 0; v.exp_rsp = '0;
        idx = f[45:40];
        if (!(f[46] && f[0] && ref_crc7({80'b0, f[47:8]}, 40) == f[7:1])) begin
            v.exp_valid = 0; v.exp_err = 1; v.exp_idx = model_idx; v.exp_arg = model_arg;
        end else begin
            v.exp_valid = 1; v.exp_err = 0; v.exp_idx = idx; v.exp_arg = f[39:8];
            if (idx == 6'd41) begin
                v.exp_len = 48; v.exp_rsp = {2'b00, 6'h3F, oc, 7'h7F, 1'b1, 88'b0};
            end else if (MASK[idx]) begin
                v.exp_len = 136; v.exp_rsp = {2'b00, 6'h3F, cid, ref_crc7(cid, 120), 1'b1};
            end else if (idx != 6'd0) begin
                v.exp_len = 48;
                v.exp_rsp = {2'b00, idx, st, ref_crc7({82'b0, idx, st}, 40), 1'b1, 88'b0};
            end
        end
    endtask

    task automatic send_frame(input logic [47:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.cmd_oe_i = 1'b1;
            bus.cmd_i    = f[47-i];
        end
        @(negedge clk);
        end_cyc      = cyc;
        bus.cmd_oe_i = 1'b0;
        bus.cmd_i    = 1'b1;
    endtask

    task automatic check_rsp(input string name, input int q0, input int r0, input int len,
                             input logic [135:0] exp);
        logic [135:0] got;
        int n;
        n = rsp_q.size() - q0;
        check({name, "_rsp_len"}, n, len);
        if (len > 0) begin
            got = '0;
            for (int i = 0; i < n && i < 136; i++) got[135-i] = rsp_q[q0+i];
            check({name, "_rsp_bits"}, got, exp);
            if (rise_q.size() > r0) check({name, "_ncr_gap"}, rise_q[r0] - end_cyc, NCR);
            else check({name, "_no_drive"}, 0, 1);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int v0, e0, q0, r0;
        v0 = valid_cnt; e0 = err_cnt; q0 = rsp_q.size(); r0 = rise_q.size();
        bus.status_i = v.status; bus.ocr_i = v.ocr; bus.cid_csd_i = v.cid;
        send_frame(v.frame, 48);
        repeat (SETTLE) @(negedge clk);
        #1;
        check({v.name, "_valid"}, valid_cnt - v0, v.exp_valid);
        check({v.name, "_err"}, err_cnt - e0, v.exp_err);
        check({v.name, "_idx"}, bus.cmd_idx_o, v.exp_idx);
        check({v.name, "_arg"}, bus.cmd_arg_o, v.exp_arg);
        check_rsp(v.name, q0, r0, v.exp_len, v.exp_rsp);
        check({v.name, "_idle"}, {bus.busy_o, bus.cmd_oe_o}, 2'b00);
        model_idx = v.exp_idx; model_arg = v.exp_arg;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [47:0]  f;
        logic [119:0] cid_a, cid_b;
        vec_t v;
        int v0, e0, q0, r0, t;

        bus.cmd_i = 1'b1; bus.cmd_oe_i = 1'b0;
        bus.status_i = '0; bus.ocr_i = '0; bus.cid_csd_i = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.cmd_o, bus.cmd_oe_o, bus.cmd_valid_o, bus.crc_err_o, bus.busy_o, bus.cmd_idx_o, bus.cmd_arg_o},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0});
        rst = 1'b0;
        @(negedge clk);

        cid_a = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;
        cid_b = 120'hA5A5_0F0F_1234_5678_9ABC_DEF0_1357_9B;
        vecs[0] = '{"cmd0", 48'h40_0000_0000_95, 32'h0, 32'h0, 120'h0, 1, 0, 6'd0, 32'h0, 0, 136'h0};
        vecs[1] = '{"cmd55", 48'h77_0000_0000_65, 32'h120, 32'h0, 120'h0, 1, 0, 6'd55, 32'h0, 48,
                    {48'h37_0000_0120_83, 88'b0}};
        vecs[2] = '{"cmd8", 48'h48_0000_01AA_87, 32'h120, 32'h0, 120'h0, 1, 0, 6'd8, 32'h1AA, 48,
                    {8'h08, 32'h120, ref_crc7({80'b0, 8'h08, 32'h120}, 40), 1'b1, 88'b0}};
        vecs[3] = '{"cmd8_badcrc", 48'h48_0000_01AA_86, 32'h120, 32'h0, 120'h0, 0, 1, 6'd8, 32'h1AA, 0, 136'h0};
        vecs[4] = '{"cmd41", mk_cmd(6'd41, 32'h40FF_8000), 32'h0, 32'h80FF_8000, 120'h0, 1, 0, 6'd41,
                    32'h40FF_8000, 48, {48'h3F_80FF_8000_FF, 88'b0}};
        vecs[5] = '{"cmd2", mk_cmd(6'd2, 32'h0), 32'h0, 32'h0, cid_a, 1, 0, 6'd2, 32'h0, 136,
                    {2'b00, 6'h3F, cid_a, ref_crc7(cid_a, 120), 1'b1}};
        f = mk_cmd(6'd17, 32'h200); f[46] = 1'b0; f[7:1] = ref_crc7({80'b0, f[47:8]}, 40);
        vecs[6] = '{"tbit_zero", f, 32'h0, 32'h0, 120'h0, 0, 1, 6'd2, 32'h0, 0, 136'h0};
        f = mk_cmd(6'd9, 32'h1234_0000); f[0] = 1'b0;
        vecs[7] = '{"endbit_zero", f, 32'h0, 32'h0, 120'h0, 0, 1, 6'd2, 32'h0, 0, 136'h0};
        vecs[8] = '{"cmd9", mk_cmd(6'd9, 32'h1234_0000), 32'h0, 32'h0, cid_b, 1, 0, 6'd9, 32'h1234_0000, 136,
                    {2'b00, 6'h3F, cid_b, ref_crc7(cid_b, 120), 1'b1}};
        vecs[9] = '{"cmd13", mk_cmd(6'd13, 32'hABCD_0000), 32'hDEAD_BEEF, 32'h0, 120'h0, 1, 0, 6'd13,
                    32'hABCD_0000, 48, {8'h0D, 32'hDEAD_BEEF, ref_crc7({80'b0, 8'h0D, 32'hDEAD_BEEF}, 40), 1'b1, 88'b0}};
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Host collides at the 10th response bit.
        v0 = valid_cnt; e0 = err_cnt; q0 = rsp_q.size();
        bus.status_i = 32'h0000_0900;
        send_frame(mk_cmd(6'd55, 32'h0), 48);
        t = 0;
        while (rsp_q.size() - q0 < 10 && t < 40) begin @(negedge clk); #1; t++; end
        check("coll_reached_bit10", rsp_q.size() - q0, 10);
        bus.cmd_i = 1'b1; bus.cmd_oe_i = 1'b1;
        @(negedge clk); #1;
        check("coll_released", {bus.cmd_oe_o, bus.busy_o}, 2'b00);
        bus.cmd_oe_i = 1'b0;
        repeat (SETTLE) @(negedge clk); #1;
        check("coll_total_bits", rsp_q.size() - q0, 10);
        check("coll_pulses", {valid_cnt - v0, err_cnt - e0}, {32'd1, 32'd0});
        model_idx = 6'd55; model_arg = 32'h0;

        // Host abandons the command after 20 bits.
        v0 = valid_cnt; e0 = err_cnt; q0 = rsp_q.size();
        send_frame(mk_cmd(6'd55, 32'h0), 20);
        repeat (80) @(negedge clk); #1;
        check("abort_pulses", {valid_cnt - v0, err_cnt - e0}, {32'd0, 32'd0});
        check("abort_no_rsp", rsp_q.size() - q0, 0);
        check("abort_idle", bus.busy_o, 1'b0);

        // Error frame followed immediately by a good one.
        v0 = valid_cnt; e0 = err_cnt; q0 = rsp_q.size(); r0 = rise_q.size();
        bus.status_i = 32'h0000_0A5A;
        send_frame(48'h48_0000_01AA_86, 48);
        send_frame(mk_cmd(6'd13, 32'h55), 48);
        repeat (SETTLE) @(negedge clk); #1;
        check("b2b_pulses", {valid_cnt - v0, err_cnt - e0}, {32'd1, 32'd1});
        check("b2b_idx_arg", {bus.cmd_idx_o, bus.cmd_arg_o}, {6'd13, 32'h55});
        check_rsp("b2b", q0, r0, 48,
                  {8'h0D, 32'h0A5A, ref_crc7({80'b0, 8'h0D, 32'h0A5A}, 40), 1'b1, 88'b0});

        // Reset while the response is on the line.
        q0 = rsp_q.size();
        send_frame(mk_cmd(6'd13, 32'h77), 48);
        t = 0;
        while (rsp_q.size() - q0 < 5 && t < 40) begin @(negedge clk); #1; t++; end
        check("rst_reached_tx", rsp_q.size() - q0, 5);
        rst = 1'b1;
        @(negedge clk); #1;
        check("rst_mid_tx",
              {bus.cmd_o, bus.cmd_oe_o, bus.cmd_valid_o, bus.crc_err_o, bus.busy_o, bus.cmd_idx_o, bus.cmd_arg_o},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0});
        rst = 1'b0;
        model_idx = '0; model_arg = '0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] idx;
            case ($urandom_range(0, 5))
                0: idx = 6'd0;
                1: idx = 6'd2;
                2: idx = 6'd41;
                3: idx = 6'd9;
                4: idx = 6'd55;
                default: idx = 6'($urandom_range(0, 63));
            endcase
            f = mk_cmd(idx, $urandom);
            case ($urandom_range(0, 7))
                5: f[1 + $urandom_range(0, 6)] ^= 1'b1;
                6: begin f[46] = 1'b0; f[7:1] = ref_crc7({80'b0, f[47:8]}, 40); end
                7: f[0] = 1'b0;
                default: ;
            endcase
            model(f, $urandom, $urandom, {$urandom, $urandom, $urandom, 24'($urandom)}, v);
            run_vec(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
